// File: rtl/aemb_wb_arb_pkg.sv
// Shared types for the aeMB WISHBONE arbiter: FSM encoding, master IDs, timeout width.
package aemb_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arbState_t;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mstId_t;

  localparam int TMO_W = 8;

endpackage

// File: rtl/aemb_wb_arb_tmo.sv
// Bus-cycle timeout counter: counts granted cycles without ack, flags the TMO-th one.
module aemb_wb_arb_tmo
  import aemb_wb_arb_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic gclk,
  input  logic grst,
  input  logic run,
  input  logic ack,
  output logic hit
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO - 1);

  logic [TMO_W-1:0] rCnt;

  // Held at zero while idle, so every grant starts counting from zero.
  always_ff @(posedge gclk) begin
    if (grst || !run) begin
      rCnt <= '0;
    end else if (!ack) begin
      rCnt <= rCnt + 1'b1;
    end
  end

  assign hit = run && (rCnt == TmoLast);

endmodule

// File: rtl/aemb_wb_arb.sv
// Two-master WISHBONE arbiter sharing XWB between aeMB IWB and DWB, alternating priority.
// Define AEMB_WB_ARB_TMO_EN to abort bus cycles that see no ack within TMO cycles.
module aemb_wb_arb
  import aemb_wb_arb_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic [29:0] iwb_adr_i,
  input  logic        iwb_stb_i,
  output logic        iwb_ack_o,
  output logic [31:0] iwb_dat_o,
  input  logic [29:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_wre_i,
  input  logic        dwb_stb_i,
  output logic        dwb_ack_o,
  output logic [31:0] dwb_dat_o,
  output logic [29:0] xwb_adr_o,
  output logic [31:0] xwb_dat_o,
  output logic [3:0]  xwb_sel_o,
  output logic        xwb_wre_o,
  output logic        xwb_stb_o,
  input  logic        xwb_ack_i,
  input  logic [31:0] xwb_dat_i,
  output logic        arb_tmo_o
);

  arbState_t rState;
  mstId_t    rLast;
  logic      gntI;
  logic      gntD;
  logic      tmoHit;
  logic      done;

  if (TMO < 1 || TMO > 255) begin : gTmoRange
    $error("aemb_wb_arb: TMO must lie within 1..255");
  end

  assign gntI = (rState == IBUS);
  assign gntD = (rState == DBUS);

`ifdef AEMB_WB_ARB_TMO_EN
  logic tmoCnt;

  aemb_wb_arb_tmo #(
    .TMO(TMO)
  ) uTmo (
    .gclk(gclk),
    .grst(grst),
    .run (gntI | gntD),
    .ack (xwb_ack_i),
    .hit (tmoCnt)
  );

  // A real ack in the timeout cycle wins, so the abort only fires without one.
  assign tmoHit = tmoCnt & ~xwb_ack_i & ~grst;
`else
  assign tmoHit = 1'b0;
`endif

  assign done      = xwb_ack_i | tmoHit;
  assign arb_tmo_o = tmoHit;
  assign iwb_ack_o = gntI & done & ~grst;
  assign dwb_ack_o = gntD & done & ~grst;
  assign iwb_dat_o = tmoHit ? 32'h0 : xwb_dat_i;
  assign dwb_dat_o = tmoHit ? 32'h0 : xwb_dat_i;

  always_ff @(posedge gclk) begin
    if (grst) begin
      rState    <= IDLE;
      rLast     <= MST_D;
      xwb_adr_o <= '0;
      xwb_dat_o <= '0;
      xwb_sel_o <= '0;
      xwb_wre_o <= 1'b0;
      xwb_stb_o <= 1'b0;
    end else begin
      case (rState)
        IDLE: begin
          // On contention the master not served last wins.
          if (iwb_stb_i && (!dwb_stb_i || rLast == MST_D)) begin
            rState    <= IBUS;
            xwb_adr_o <= iwb_adr_i;
            xwb_sel_o <= 4'hF;
            xwb_wre_o <= 1'b0;
            xwb_stb_o <= 1'b1;
          end else if (dwb_stb_i) begin
            rState    <= DBUS;
            xwb_adr_o <= dwb_adr_i;
            xwb_dat_o <= dwb_dat_i;
            xwb_sel_o <= dwb_sel_i;
            xwb_wre_o <= dwb_wre_i;
            xwb_stb_o <= 1'b1;
          end
        end
        IBUS, DBUS: begin
          if (done) begin
            rState    <= IDLE;
            rLast     <= gntD ? MST_D : MST_I;
            xwb_stb_o <= 1'b0;
            xwb_wre_o <= 1'b0;
          end
        end
        default: rState <= IDLE;
      endcase
    end
  end

endmodule
